// File: rtl/lif_pkg.sv
// Shared types, default widths and helpers for the multi-channel LIF neuron.
package lif_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        INTEGRATE  = 2'd1,
        REFRACTORY = 2'd2
    } lif_state_e;

    localparam int DEF_N_CH    = 4;
    localparam int DEF_IN_W    = 6;
    localparam int DEF_W_W     = 4;
    localparam int DEF_V_W     = 8;
    localparam int DEF_ADAPT_W = 6;

    // Wide enough for N_CH products of unsigned IN_W by signed W_W, plus sign.
    function automatic int sum_w(input int n_ch, input int in_w, input int w_w);
        return in_w + w_w + $clog2(n_ch) + 1;
    endfunction

    // Clamp a signed value into the unsigned range [0, 2^w-1].
    function automatic logic [31:0] clamp_u(input logic signed [31:0] val, input int w);
        longint maxv;
        maxv = (64'sd1 << w) - 64'sd1;
        if (val < 0) begin
            return 32'd0;
        end
        if (longint'(val) > maxv) begin
            return 32'(maxv);
        end
        return 32'(val);
    endfunction

endpackage

// File: rtl/lif_weighted_sum.sv
// Combinational N_CH multiply-accumulate: unsigned inputs times signed weights,
// reduced through a balanced binary adder tree padded to a power of two.
module lif_weighted_sum
    import lif_pkg::*;
#(
    parameter int N_CH = DEF_N_CH,
    parameter int IN_W = DEF_IN_W,
    parameter int W_W  = DEF_W_W
) (
    input  logic [N_CH*IN_W-1:0]                      chan_i,
    input  logic [N_CH*W_W-1:0]                       weights_i,
    output logic signed [sum_w(N_CH, IN_W, W_W)-1:0]  sum_o
);

    localparam int SUM_W = sum_w(N_CH, IN_W, W_W);
    localparam int LVLS  = $clog2(N_CH);
    localparam int NL    = 1 << LVLS;

    logic signed [SUM_W-1:0] node [NL];

    always_comb begin
        for (int i = 0; i < NL; i++) begin
            node[i] = '0;
        end
        for (int i = 0; i < N_CH; i++) begin
            node[i] = SUM_W'($signed({1'b0, chan_i[i*IN_W +: IN_W]}) *
                             $signed(weights_i[i*W_W +: W_W]));
        end
        // Each level halves the live node count, folding pairs in place.
        for (int l = 0; l < LVLS; l++) begin
            for (int k = 0; k < (NL >> (l + 1)); k++) begin
                node[k] = node[2*k] + node[2*k+1];
            end
        end
        sum_o = node[0];
    end

endmodule

// File: rtl/lif_multi_neuron.sv
// Leaky integrate-and-fire neuron with signed weighted inputs, periodic leak,
// refractory period and optional spike-driven adaptive threshold.
module lif_multi_neuron
    import lif_pkg::*;
#(
    parameter int N_CH    = DEF_N_CH,
    parameter int IN_W    = DEF_IN_W,
    parameter int W_W     = DEF_W_W,
    parameter int V_W     = DEF_V_W,
    parameter int ADAPT_W = DEF_ADAPT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 input_enable,
    input  logic                 params_ready,
    input  logic [N_CH*IN_W-1:0] chan,
    input  logic [N_CH*W_W-1:0]  weights,
    input  logic [V_W-1:0]       leak_rate,
    input  logic [V_W-1:0]       threshold,
    input  logic [3:0]           leak_cycles,
    input  logic [3:0]           refrac_period,
    input  logic                 adapt_en,
    input  logic [ADAPT_W-1:0]   adapt_step,
    output logic                 spike_out,
    output logic [V_W-1:0]       v_mem_out,
    output logic [V_W:0]         thr_eff_out,
    output logic                 in_refrac
);

    localparam int SUM_W = sum_w(N_CH, IN_W, W_W);
    localparam int NV_W  = ((SUM_W > V_W + 1) ? SUM_W : V_W + 1) + 2;

    lif_state_e           state_q, state_d;
    logic [V_W-1:0]       v_mem_q, v_mem_d;
    logic [3:0]           refr_cnt_q, refr_cnt_d;
    logic [3:0]           leak_cnt_q, leak_cnt_d;
    logic [ADAPT_W-1:0]   adapt_q, adapt_d;
    logic                 spike_q, spike_d;
    logic [V_W:0]         thr_eff_q, thr_eff_d;

    logic signed [SUM_W-1:0] sum;
    logic signed [NV_W-1:0]  v_ext, sum_ext, leak_ext, new_v;
    logic [V_W-1:0]          v_new;
    logic [V_W:0]            thr_now;
    logic [ADAPT_W:0]        adapt_sum;
    logic [ADAPT_W-1:0]      adapt_inc;
    logic                    active, leak_tick, spike_now;

    lif_weighted_sum #(
        .N_CH (N_CH),
        .IN_W (IN_W),
        .W_W  (W_W)
    ) u_sum (
        .chan_i    (chan),
        .weights_i (weights),
        .sum_o     (sum)
    );

    always_comb begin
        active    = enable && params_ready;
        leak_tick = active && (leak_cnt_q >= leak_cycles);
        thr_now   = {1'b0, threshold} + (adapt_en ? (V_W+1)'(adapt_q) : '0);

        v_ext     = NV_W'(v_mem_q);
        sum_ext   = NV_W'(sum);
        leak_ext  = leak_tick ? NV_W'(leak_rate) : '0;
        new_v     = v_ext + sum_ext - leak_ext;
        v_new     = V_W'(clamp_u(32'(new_v), V_W));
        spike_now = ({1'b0, v_new} >= thr_now);

        adapt_sum = {1'b0, adapt_q} + {1'b0, adapt_step};
        adapt_inc = adapt_sum[ADAPT_W] ? '1 : adapt_sum[ADAPT_W-1:0];
    end

    always_comb begin
        state_d    = state_q;
        v_mem_d    = v_mem_q;
        refr_cnt_d = refr_cnt_q;
        leak_cnt_d = leak_cnt_q;
        adapt_d    = adapt_q;
        spike_d    = 1'b0;

        if (!active) begin
            state_d = IDLE;
        end else begin
            leak_cnt_d = leak_tick ? 4'd0 : leak_cnt_q + 4'd1;
            // A spike in this cycle overrides the decay below.
            if ((state_q != IDLE) && leak_tick && (adapt_q != '0)) begin
                adapt_d = adapt_q - ADAPT_W'(1);
            end
            unique case (state_q)
                IDLE: begin
                    state_d = INTEGRATE;
                end
                INTEGRATE: begin
                    if (input_enable) begin
                        if (spike_now) begin
                            spike_d    = 1'b1;
                            v_mem_d    = '0;
                            refr_cnt_d = refrac_period;
                            adapt_d    = adapt_inc;
                            if (refrac_period != 4'd0) begin
                                state_d = REFRACTORY;
                            end
                        end else begin
                            v_mem_d = v_new;
                        end
                    end
                end
                REFRACTORY: begin
                    v_mem_d = '0;
                    if (refr_cnt_q <= 4'd1) begin
                        refr_cnt_d = 4'd0;
                        state_d    = INTEGRATE;
                    end else begin
                        refr_cnt_d = refr_cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        thr_eff_d = {1'b0, threshold} + (adapt_en ? (V_W+1)'(adapt_d) : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            v_mem_q    <= '0;
            refr_cnt_q <= '0;
            leak_cnt_q <= '0;
            adapt_q    <= '0;
            spike_q    <= 1'b0;
            thr_eff_q  <= '0;
        end else begin
            state_q    <= state_d;
            v_mem_q    <= v_mem_d;
            refr_cnt_q <= refr_cnt_d;
            leak_cnt_q <= leak_cnt_d;
            adapt_q    <= adapt_d;
            spike_q    <= spike_d;
            thr_eff_q  <= thr_eff_d;
        end
    end

    assign spike_out   = spike_q;
    assign v_mem_out   = v_mem_q;
    assign thr_eff_out = thr_eff_q;
    assign in_refrac   = (state_q == REFRACTORY);

endmodule

// File: doc/lif_multi_neuron.md
Name: lif_multi_neuron

Overview:
Parametrised next-generation LIF neuron for the Tiny Tapeout SNN datapath.
- Integrates N_CH weighted input channels with signed (excitatory/inhibitory) weights.
- Applies periodic leak and a programmable refractory period.
- Optional adaptive threshold that rises on each spike and decays on leak ticks.
- Sits between the parameter loader and the spike router; one instance per neuron.

Parameters:
N_CH, 4, number of input channels (1..8)
IN_W, 6, unsigned input channel width
W_W, 4, signed two's-complement weight width
V_W, 8, membrane potential / threshold width (unsigned range 0..2^V_W-1)
ADAPT_W, 6, adaptation accumulator width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  global neuron enable
input_enable  in  1  integrate inputs this cycle
params_ready  in  1  loader configuration valid
chan  in  N_CH*IN_W  packed unsigned inputs; channel i at [i*IN_W +: IN_W]
weights  in  N_CH*W_W  packed signed weights; channel i at [i*W_W +: W_W]
leak_rate  in  V_W  amount subtracted on a leak tick
threshold  in  V_W  base firing threshold
leak_cycles  in  4  leak tick period minus one
refrac_period  in  4  refractory length in active cycles; 0 = none
adapt_en  in  1  enable threshold adaptation
adapt_step  in  ADAPT_W  adaptation increment per spike
spike_out  out  1  one-cycle spike pulse, registered
v_mem_out  out  V_W  current membrane potential
thr_eff_out  out  V_W+1  effective threshold (threshold + adapt)
in_refrac  out  1  high while in REFRACTORY

Behaviour:
Reset (async, rst_n=0):
- v_mem, refr_cnt, leak_cnt, adapt, spike_out all 0; FSM = IDLE.
- Applies immediately, including mid-refractory; release is synchronous to clk.

Active cycle: enable && params_ready. Otherwise:
- FSM → IDLE, spike_out=0, all other state held.

FSM transitions:
- IDLE → INTEGRATE on the first active cycle.
- INTEGRATE → REFRACTORY on a spike when refrac_period≠0.
- REFRACTORY → INTEGRATE in the cycle refr_cnt decrements 1→0.

Leak counter (every active cycle, any state):
- leak_tick = (leak_cnt >= leak_cycles).
- On leak_tick, leak_cnt → 0; otherwise leak_cnt+1.
- leak_cycles=0 gives a tick every active cycle.

Integration (INTEGRATE && input_enable):
- sum = Σ chan[i]*weights[i], signed, width IN_W+W_W+clog2(N_CH)+1, no overflow possible.
- new_v = v_mem + sum − (leak_tick ? leak_rate : 0), computed wide and signed.
- Clamp new_v to [0, 2^V_W−1].
- thr_eff = threshold + (adapt_en ? adapt : 0), V_W+1 bits unsigned.
- Spike if new_v >= thr_eff: spike_out=1, v_mem=0, refr_cnt=refrac_period, adapt=min(adapt+adapt_step, 2^ADAPT_W−1).
- No spike: spike_out=0, v_mem=new_v.
- threshold=0 with adapt 0 spikes on every integrating cycle.

INTEGRATE && !input_enable: hold v_mem, spike_out=0; leak is NOT applied.

REFRACTORY:
- refr_cnt−1 each active cycle; spike_out=0; v_mem held at 0; inputs ignored.

Adaptation decay:
- On leak_tick with no spike this cycle, adapt−1, floored at 0. Applies in any non-IDLE state.
- adapt_en=0: adapt still accumulates and decays but is not added into thr_eff.

Output timing:
- Latency: input sample to spike_out/v_mem_out = 1 clk.
- Outputs are registered or decoded directly from registered state; no combinational input→output path.

Decomposition:
- Package lif_pkg: FSM state enum (IDLE, INTEGRATE, REFRACTORY), default widths, the clamp helper function, and the SUM_W width computation.
- One sub-module: lif_weighted_sum, a combinational N_CH multiply-accumulate with a parametrised tree adder.
- FSM, counters and clamping stay in lif_multi_neuron.

Test Plan:
1. N_CH=2, chan0=5, w0=3, chan1=0, threshold=60, leak_cycles=15, leak_rate=0, refrac=4 → v_mem_out 15,30,45; spike_out=1 on cycle 4; v_mem 0; in_refrac high 4 active cycles with inputs ignored; next integrations give 15,30,...
2. chan0=5, w0=3, chan1=10, w1=−4 (sum −25) from v_mem=45 → v_mem_out 20, then 0 (clamped, never negative); no spike.
3. chan0=63, w0=7, chan1=63, w1=7, threshold=255 → new_v clamps to 255 and spikes on the first cycle; with threshold=0 → spike on every non-refractory integrating cycle.
4. leak_cycles=0, leak_rate=5, input +15/cycle, threshold=200 → v_mem_out 10,20,30,...; drop enable for 3 cycles → values held, spike_out=0, FSM IDLE, resumes at the next value.
5. adapt_en=1, adapt_step=10, threshold=60, refrac=0 → thr_eff_out 60 then 70 after spike 1, 80 after spike 2; with input 0 and leak_cycles=3, thr_eff_out decays by 1 every 4 active cycles back to 60.
6. Assert rst_n=0 asynchronously mid-refractory (refr_cnt=2, adapt=20) → all outputs 0 before the next clk edge; after release, the first active cycle integrates from v_mem=0, thr_eff=threshold.
